// File: rtl/cla_sum_stage_if.sv
// Bundle of the issue-side and result-side signals of the lookahead-adder sum stage.
// The producer/consumer environment uses the master view; the sum stage uses the slave view.
interface cla_sum_stage_if #(
  parameter int WIDTH = 16
);
  logic             issue_valid;
  logic             issue_ok;
  logic [WIDTH-1:0] half_sum;
  logic [WIDTH-1:0] carry;
  logic             carry_top;
  logic             sum_valid;
  logic             sum_ready;
  logic [WIDTH-1:0] sum;
  logic             sum_cout;
  logic             overflow_err;

  modport master (
    output issue_valid, half_sum, carry, carry_top, sum_ready,
    input  issue_ok, sum_valid, sum, sum_cout, overflow_err
  );

  modport slave (
    input  issue_valid, half_sum, carry, carry_top, sum_ready,
    output issue_ok, sum_valid, sum, sum_cout, overflow_err
  );
endinterface

// File: rtl/cla_sum_stage.sv
// Final stage of the pipelined 16-bit lookahead adder. Half-sums are delayed LAT
// cycles so they meet the registered carries, combined into sum = p ^ c, and queued
// in a small FIFO. Upstream issue is credit-gated by in-flight plus queued results.
module cla_sum_stage #(
  parameter int WIDTH = 16,
  parameter int LAT   = 2,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  cla_sum_stage_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(LAT + 1);
  localparam int OW = $clog2(DEPTH + LAT + 1);

  // FIFO entry layout: {sum, carry-out}
  typedef logic [WIDTH:0] entry_t;

  logic [LAT-1:0]   dl_vld_q, dl_vld_d;
  logic [WIDTH-1:0] dl_hs_q [LAT];
  logic [WIDTH-1:0] dl_hs_d [LAT];
  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;

  logic             tap_vld_s;
  logic [WIDTH-1:0] tap_hs_s;
  logic             empty_s;
  logic             full_s;
  logic             pop_s;
  logic             push_s;
  logic             drop_s;
  logic [IW-1:0]    inflight_s;
  logic [OW-1:0]    occ_s;
  logic [PW-1:0]    rd_idx_s;

  assign tap_vld_s = dl_vld_q[LAT-1];
  assign tap_hs_s  = dl_hs_q[LAT-1];
  assign empty_s   = (count_q == {CW{1'b0}});
  assign full_s    = (count_q == CW'(DEPTH));
  assign pop_s     = !empty_s && bus.sum_ready;
  // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
  assign push_s    = tap_vld_s && (!full_s || pop_s);
  assign drop_s    = tap_vld_s && full_s && !pop_s;

  // Delay-line shift: stage 0 samples the issue, each later stage copies its predecessor
  always_comb begin
    dl_vld_d[0] = bus.issue_valid;
    dl_hs_d[0]  = bus.half_sum;
    for (int i = 1; i < LAT; i++) begin
      dl_vld_d[i] = dl_vld_q[i-1];
      dl_hs_d[i]  = dl_hs_q[i-1];
    end
  end

  // Count valid delay-line stages for the credit check
  always_comb begin
    inflight_s = {IW{1'b0}};
    for (int i = 0; i < LAT; i++) begin
      inflight_s = inflight_s + IW'(dl_vld_q[i]);
    end
  end

  assign occ_s        = OW'(inflight_s) + OW'(count_q);
  assign bus.issue_ok = (occ_s < OW'(DEPTH));

  // FIFO next state: write at tap, read on handshake, sticky overflow on a dropped result
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = {tap_hs_s ^ bus.carry, bus.carry_top};
      wr_ptr_d        = wr_ptr_q + PW'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1'b1);
      2'b01:   count_d = count_q - CW'(1'b1);
      default: count_d = count_q;
    endcase
    if (drop_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // When empty, the last popped entry sits just behind rd_ptr, which keeps the outputs steady
  always_comb begin
    if (empty_s) begin
      rd_idx_s = rd_ptr_q - PW'(1'b1);
    end else begin
      rd_idx_s = rd_ptr_q;
    end
  end

  assign bus.sum_valid    = !empty_s;
  assign bus.sum          = mem_q[rd_idx_s][WIDTH:1];
  assign bus.sum_cout     = mem_q[rd_idx_s][0];
  assign bus.overflow_err = ovf_q;

  // State registers; reset discards every in-flight and queued result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_vld_q <= {LAT{1'b0}};
      for (int i = 0; i < LAT; i++) begin
        dl_hs_q[i] <= {WIDTH{1'b0}};
      end
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {(WIDTH+1){1'b0}};
      end
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      ovf_q    <= 1'b0;
    end else begin
      dl_vld_q <= dl_vld_d;
      dl_hs_q  <= dl_hs_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule
